// File: rtl/ocd_lvl_mc.sv
// ocd_lvl_mc: multi-channel PWM level generator with shadowed level registers.
//
// A single down-counter (PAR_MAX_VAL-1 .. 0) defines the PWM period. Each
// channel owns a bus-writable shadow level and an active level. The active
// level reloads from the shadow only at that channel's own period end, so
// level changes never cut into a running period. With stagger enabled, each
// channel's phase is offset by i*(PAR_MAX_VAL/CH_NUM) clocks.
//
// Ports
//   clk    : system clock, rising edge
//   rst    : synchronous active-high reset
//   pw_par : write data (W bits)
//   addr   : write address (A bits)
//   en     : write strobe
//   out    : registered per-channel PWM outputs
//   sync   : one-cycle pulse at the global period boundary
module ocd_lvl_mc #(
  parameter int CLK_MHZ     = 100,
  parameter int PAR_MAX_VAL = 255,
  parameter int ADDR_MAX    = 7,
  parameter int ADDR        = 4,
  parameter int CH_NUM      = 4,
  localparam int W = $clog2(PAR_MAX_VAL + 1),
  localparam int A = $clog2(ADDR_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W-1:0]      pw_par,
  input  logic [A-1:0]      addr,
  input  logic              en,
  output logic [CH_NUM-1:0] out,
  output logic              sync
);

  localparam int STEP = PAR_MAX_VAL / CH_NUM;

  if ((ADDR + CH_NUM > ADDR_MAX) || (CH_NUM < 1) || (CH_NUM > 16) ||
      (PAR_MAX_VAL < 2) || (CLK_MHZ < 1)) begin : g_param_check
    $error("ocd_lvl_mc: illegal parameter combination");
  end

  // Phase of channel i; the sum is formed one bit wider so it cannot wrap
  // before the modulo, and both addends are below PAR_MAX_VAL so a single
  // conditional subtract is enough.
  function automatic logic [W-1:0] phase_wrap(input logic [W-1:0] c, input int i);
    logic [W:0] s;
    s = {1'b0, c} + (W+1)'(i * STEP);
    if (s >= (W+1)'(PAR_MAX_VAL))
      s = s - (W+1)'(PAR_MAX_VAL);
    return s[W-1:0];
  endfunction

  logic [W-1:0]      cnt_p0;
  logic [W-1:0]      shadow [CH_NUM];
  logic [W-1:0]      active [CH_NUM];
  logic              out_en;
  logic              stagger;
  logic [W-1:0]      pcnt_p0 [CH_NUM];
  logic [CH_NUM-1:0] out_p1;
  logic              sync_p1;

  // Stage 0: per-channel phase derived from the global counter
  always_comb begin
    for (int i = 0; i < CH_NUM; i++) begin
      pcnt_p0[i] = cnt_p0;
      if (stagger)
        pcnt_p0[i] = phase_wrap(cnt_p0, i);
    end
  end

  // Stage 1: counter, level commit, bus writes and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p0  <= W'(PAR_MAX_VAL - 1);
      out_en  <= 1'b1;
      stagger <= 1'b0;
      out_p1  <= '0;
      sync_p1 <= 1'b0;
      for (int i = 0; i < CH_NUM; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      cnt_p0  <= (cnt_p0 == '0) ? W'(PAR_MAX_VAL - 1) : cnt_p0 - 1'b1;
      sync_p1 <= (cnt_p0 == '0);
      for (int i = 0; i < CH_NUM; i++) begin
        // Commit reads the shadow as it stood before this edge, so a write
        // landing on the commit cycle waits for the next period end.
        if (pcnt_p0[i] == '0)
          active[i] <= shadow[i];
        out_p1[i] <= out_en & (pcnt_p0[i] < active[i]);
      end
      if (en) begin
        for (int i = 0; i < CH_NUM; i++) begin
          if (addr == A'(ADDR + i))
            shadow[i] <= pw_par;
        end
        if (addr == A'(ADDR + CH_NUM))
          {stagger, out_en} <= pw_par[1:0];
      end
    end
  end

  assign out  = out_p1;
  assign sync = sync_p1;

endmodule

// File: tb/tb_ocd_lvl_mc.sv
// tb_ocd_lvl_mc: directed bench for ocd_lvl_mc with PAR_MAX_VAL=255,
// CH_NUM=4, ADDR=4, ADDR_MAX=15. Outputs are sampled 1 ns after each
// rising edge; expected values are hand-derived constants.
module tb_ocd_lvl_mc;

  logic       clk;
  logic       rst;
  logic [7:0] pw_par;
  logic [3:0] addr;
  logic       en;
  logic [3:0] out;
  logic       sync;

  int checks;
  int errors;

  int hi   [4];
  int rise [4];
  int rpos [4];
  int ns;
  int spos;
  int nwait;

  ocd_lvl_mc #(
    .CLK_MHZ    (100),
    .PAR_MAX_VAL(255),
    .ADDR_MAX   (15),
    .ADDR       (4),
    .CH_NUM     (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .pw_par(pw_par),
    .addr  (addr),
    .en    (en),
    .out   (out),
    .sync  (sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    addr   = a;
    pw_par = d;
    en     = 1'b1;
    tick();
    en     = 1'b0;
  endtask

  // Advance until sync is seen (returns immediately if already high).
  task automatic wait_sync(output int n);
    n = 0;
    while (!sync && n < 600) begin
      tick();
      n++;
    end
    chk("sync_seen", int'(sync), 1);
  endtask

  // Observe one full 255-clock period starting right after a sync sample.
  // Optionally performs one write whose edge is period cycle wcyc.
  task automatic period(input int wcyc, input logic [3:0] wa, input logic [7:0] wd);
    logic [3:0] prev;
    prev = out;
    for (int i = 0; i < 4; i++) begin
      hi[i] = 0; rise[i] = 0; rpos[i] = -1;
    end
    ns   = 0;
    spos = -1;
    for (int c = 0; c < 255; c++) begin
      if (c == wcyc) begin
        addr = wa; pw_par = wd; en = 1'b1;
      end
      tick();
      en = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (out[i]) hi[i]++;
        if (out[i] && !prev[i]) begin
          rise[i]++;
          rpos[i] = c;
        end
      end
      if (sync) begin
        ns++;
        spos = c;
      end
      prev = out;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    en     = 1'b0;
    addr   = '0;
    pw_par = '0;

    // Reset state
    run(3);
    chk("rst_out", int'(out), 0);
    chk("rst_sync", int'(sync), 0);
    rst = 1'b0;

    // Channel 0 level 64; first period after the write still shows 0
    wait_sync(nwait);
    chk("first_sync_dist", nwait, 255);
    period(0, 4'd4, 8'd64);
    chk("ch0_write_period", hi[0], 0);
    for (int p = 0; p < 3; p++) begin
      period(-1, 4'd0, 8'd0);
      chk("ch0_hi64", hi[0], 64);
      chk("ch1_zero", hi[1], 0);
      chk("ch2_zero", hi[2], 0);
      chk("ch3_zero", hi[3], 0);
      chk("ch0_rise", rise[0], 1);
      chk("sync_count", ns, 1);
      chk("sync_pos", spos, 254);
    end

    // Channel 1: 30, then 100 written mid-period
    period(0, 4'd5, 8'd30);
    chk("ch1_before30", hi[1], 0);
    period(128, 4'd5, 8'd100);
    chk("ch1_hi30", hi[1], 30);
    chk("ch1_rise30", rise[1], 1);
    period(-1, 4'd0, 8'd0);
    chk("ch1_hi100", hi[1], 100);
    chk("ch1_rise100", rise[1], 1);
    chk("ch0_keep64", hi[0], 64);

    // Stagger on, all channels at 128
    wr(4'd4, 8'd128);
    wr(4'd5, 8'd128);
    wr(4'd6, 8'd128);
    wr(4'd7, 8'd128);
    wr(4'd8, 8'd3);
    run(600);
    wait_sync(nwait);
    period(-1, 4'd0, 8'd0);
    chk("stg_hi0", hi[0], 128);
    chk("stg_hi1", hi[1], 128);
    chk("stg_hi2", hi[2], 128);
    chk("stg_hi3", hi[3], 128);
    chk("stg_rpos0", rpos[0], 127);
    chk("stg_rpos1", rpos[1], 190);
    chk("stg_rpos2", rpos[2], 253);
    chk("stg_rpos3", rpos[3], 61);
    chk("stg_rise1", rise[1], 1);

    // Channel 2 at 0 and at 255
    wr(4'd6, 8'd0);
    run(520);
    wait_sync(nwait);
    period(-1, 4'd0, 8'd0);
    chk("ch2_lvl0", hi[2], 0);
    wr(4'd6, 8'd255);
    run(520);
    wait_sync(nwait);
    period(-1, 4'd0, 8'd0);
    chk("ch2_lvl255", hi[2], 255);
    chk("ch2_norise", rise[2], 0);
    chk("ch2_high_pre", int'(out[2]), 1);

    // Output enable off
    addr = 4'd8; pw_par = 8'd0; en = 1'b1;
    tick();
    en = 1'b0;
    tick();
    chk("oe_off_out", int'(out), 0);
    wait_sync(nwait);
    period(-1, 4'd0, 8'd0);
    chk("oe_off_hi0", hi[0], 0);
    chk("oe_off_hi2", hi[2], 0);

    // Out-of-range addresses ignored
    wr(4'd8, 8'd1);
    wr(4'd3, 8'd0);
    wr(4'd9, 8'd0);
    run(600);
    wait_sync(nwait);
    period(-1, 4'd0, 8'd0);
    chk("ign_hi0", hi[0], 128);
    chk("ign_hi1", hi[1], 128);
    chk("ign_hi2", hi[2], 255);
    chk("ign_hi3", hi[3], 128);
    chk("ign_rpos0", rpos[0], 127);

    // Mid-period reset with a concurrent write
    run(100);
    rst = 1'b1; en = 1'b1; addr = 4'd4; pw_par = 8'd200;
    tick();
    chk("midrst_out", int'(out), 0);
    chk("midrst_sync", int'(sync), 0);
    rst = 1'b0; en = 1'b0;
    wait_sync(nwait);
    chk("post_rst_len", nwait, 255);
    period(-1, 4'd0, 8'd0);
    chk("post_rst_hi0", hi[0], 0);
    chk("post_rst_hi2", hi[2], 0);
    chk("post_rst_sync", spos, 254);

    // Control defaults after reset: enabled, not staggered
    wr(4'd5, 8'd50);
    wait_sync(nwait);
    period(-1, 4'd0, 8'd0);
    chk("post_rst_hi1", hi[1], 50);
    chk("post_rst_rpos1", rpos[1], 205);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
